cache_mem_ctrl: RTL and testbench

CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

---
 rtl/cache_mem_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_cache_mem_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_ctrl.sv
// Two-port (fetch/data) controller in front of a write-through cache and a word RAM.
// Define CACHE_MEM_CTRL_CACHE_EN to use the cache; undefined, every access goes to RAM.
module cache_mem_ctrl #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_oe,
    output logic                  cache_we,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_found
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        CHECK   = 3'd2,
        RDISSUE = 3'd3,
        RAM_RD  = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                  state_r;
    logic                    last_data_r;
    logic                    owner_data_r;
    logic [ADDR_WIDTH-1:0]   lat_addr_r;
    logic                    grant_data_s;
    logic                    sel_write_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;

    // Round-robin pick: on a tie the port that did not win last time goes first.
    function automatic logic pick_data(input logic f, input logic d, input logic last_data);
        logic p;
        if (f && d) begin
            p = !last_data;
        end else if (d) begin
            p = 1'b1;
        end else begin
            p = 1'b0;
        end
        return p;
    endfunction

    // Winner selection and its address/direction, evaluated only in IDLE.
    always_comb begin
        grant_data_s = pick_data(f_req, d_req, last_data_r);
        sel_addr_s   = grant_data_s ? d_addr : f_addr;
        sel_write_s  = grant_data_s & d_we;
    end

`ifdef CACHE_MEM_CTRL_CACHE_EN
    logic                  cache_oe_r;
    logic                  cache_we_r;
    logic [ADDR_WIDTH-1:0] cache_addr_r;
    logic [DATA_WIDTH-1:0] cache_wdata_r;
    logic                  fill_r;

    // During a miss fill the returning RAM word goes straight into the cache.
    assign cache_oe    = cache_oe_r;
    assign cache_we    = cache_we_r;
    assign cache_addr  = cache_addr_r;
    assign cache_wdata = fill_r ? ram_rdata : cache_wdata_r;
`else
    logic unused_cache_s;

    assign cache_oe       = 1'b0;
    assign cache_we       = 1'b0;
    assign cache_addr     = '0;
    assign cache_wdata    = '0;
    assign unused_cache_s = ^{cache_rdata, cache_found};
`endif

    // Transaction FSM; strobes are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_data_r  <= 1'b1;
            owner_data_r <= 1'b0;
            lat_addr_r   <= '0;
            f_ack        <= 1'b0;
            d_ack        <= 1'b0;
            busy         <= 1'b0;
            rdata        <= '0;
            ram_addr     <= '0;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_wdata    <= '0;
`ifdef CACHE_MEM_CTRL_CACHE_EN
            cache_oe_r    <= 1'b0;
            cache_we_r    <= 1'b0;
            cache_addr_r  <= '0;
            cache_wdata_r <= '0;
            fill_r        <= 1'b0;
`endif
        end else begin
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_wdata <= '0;
`ifdef CACHE_MEM_CTRL_CACHE_EN
            cache_oe_r    <= 1'b0;
            cache_we_r    <= 1'b0;
            cache_addr_r  <= '0;
            cache_wdata_r <= '0;
            fill_r        <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (f_req || d_req) begin
                        last_data_r  <= grant_data_s;
                        owner_data_r <= grant_data_s;
                        lat_addr_r   <= sel_addr_s;
                        busy         <= 1'b1;
                        if (sel_write_s) begin
                            state_r   <= WRITE;
                            ram_cs    <= 1'b1;
                            ram_we    <= 1'b1;
                            ram_addr  <= sel_addr_s;
                            ram_wdata <= d_wdata;
`ifdef CACHE_MEM_CTRL_CACHE_EN
                            cache_we_r    <= 1'b1;
                            cache_addr_r  <= sel_addr_s;
                            cache_wdata_r <= d_wdata;
`endif
                        end else begin
`ifdef CACHE_MEM_CTRL_CACHE_EN
                            state_r      <= LOOKUP;
                            cache_oe_r   <= 1'b1;
                            cache_addr_r <= sel_addr_s;
`else
                            state_r  <= RDISSUE;
                            ram_cs   <= 1'b1;
                            ram_oe   <= 1'b1;
                            ram_addr <= sel_addr_s;
`endif
                        end
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
`ifdef CACHE_MEM_CTRL_CACHE_EN
                // Keep the cache enabled through CHECK so hit data is stable when sampled.
                LOOKUP: begin
                    state_r      <= CHECK;
                    cache_oe_r   <= 1'b1;
                    cache_addr_r <= lat_addr_r;
                end
                CHECK: begin
                    if (cache_found) begin
                        rdata   <= cache_rdata;
                        state_r <= DONE;
                        f_ack   <= !owner_data_r;
                        d_ack   <= owner_data_r;
                    end else begin
                        state_r      <= RAM_RD;
                        ram_cs       <= 1'b1;
                        ram_oe       <= 1'b1;
                        ram_addr     <= lat_addr_r;
                        cache_we_r   <= 1'b1;
                        cache_addr_r <= lat_addr_r;
                        fill_r       <= 1'b1;
                    end
                end
`endif
                RDISSUE: begin
                    state_r  <= RAM_RD;
                    ram_cs   <= 1'b1;
                    ram_oe   <= 1'b1;
                    ram_addr <= lat_addr_r;
                end
                RAM_RD: begin
                    rdata   <= ram_rdata;
                    state_r <= DONE;
                    f_ack   <= !owner_data_r;
                    d_ack   <= owner_data_r;
                end
                WRITE: begin
                    state_r <= DONE;
                    f_ack   <= !owner_data_r;
                    d_ack   <= owner_data_r;
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: directed transactions push expected acks,
// a negedge monitor pops and compares port, latency and rdata.
`timescale 1ns/1ps
module tb_cache_mem_ctrl;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int WR_LAT = 2;
`ifdef CACHE_MEM_CTRL_CACHE_EN
    localparam int MISS_LAT = 4;
    localparam int HIT_LAT  = 3;
    localparam int RD_CYC   = 3;
    localparam logic [31:0] T3_RD = 32'h7800_0000;
    localparam logic [31:0] T5_RD = 32'h5A5A_5A5A;
`else
    localparam int MISS_LAT = 3;
    localparam int HIT_LAT  = 3;
    localparam int RD_CYC   = 2;
    localparam logic [31:0] T3_RD = 32'h2222_3333;
    localparam logic [31:0] T5_RD = 32'h7800_0001;
`endif

    logic          clk, reset;
    logic          f_req, f_ack, d_req, d_we, d_ack, busy;
    logic [AW-1:0] f_addr, d_addr, ram_addr, cache_addr;
    logic [DW-1:0] d_wdata, rdata, ram_wdata, ram_rdata, cache_wdata, cache_rdata;
    logic          ram_cs, ram_we, ram_oe, cache_oe, cache_we, cache_found;

    cache_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cache_addr(cache_addr), .cache_oe(cache_oe), .cache_we(cache_we),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_found(cache_found)
    );

    typedef struct {
        logic        is_d;
        int          start;
        int          lat;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          viol = 0;
    logic [31:0] model_rd = 32'h0;

    logic          seen_ram_cs, seen_ram_we, seen_cache_we, seen_both;
    logic [AW-1:0] obs_ram_addr, obs_cache_addr;
    logic [DW-1:0] obs_ram_wdata, obs_cache_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (f_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {62'd0, f_ack, d_ack}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {62'd0, f_ack, d_ack}, e.is_d ? 64'd1 : 64'd2);
                check("ack_latency", 64'(cyc - e.start), 64'(e.lat));
                check("rdata", {32'd0, rdata}, {32'd0, e.rd});
            end
        end
    end

    // Bus rules that must hold every cycle
    always @(negedge clk) begin
        logic bad;
        bad = 1'b0;
        if (ram_we && ram_oe) bad = 1'b1;
        if (!busy && (ram_cs || ram_we || ram_oe || cache_oe || cache_we)) bad = 1'b1;
        if ((f_ack || d_ack) && (ram_cs || ram_we || ram_oe || cache_oe || cache_we)) bad = 1'b1;
        if (f_ack && d_ack) bad = 1'b1;
`ifndef CACHE_MEM_CTRL_CACHE_EN
        if (cache_oe || cache_we || (cache_addr != 24'd0) || (cache_wdata != 32'd0)) bad = 1'b1;
`endif
        if (bad) begin
            viol++;
            if (viol <= 5) $display("FAIL bus_rule at cycle %0d: cs=%b we=%b oe=%b coe=%b cwe=%b busy=%b", cyc, ram_cs, ram_we, ram_oe, cache_oe, cache_we, busy);
        end
    end

    task automatic sample_bus();
        if (ram_cs) seen_ram_cs = 1'b1;
        if (ram_cs && ram_oe) obs_ram_addr = ram_addr;
        if (ram_we) begin
            seen_ram_we   = 1'b1;
            obs_ram_addr  = ram_addr;
            obs_ram_wdata = ram_wdata;
        end
        if (ram_we && cache_we) seen_both = 1'b1;
        if (cache_oe) obs_cache_addr = cache_addr;
        if (cache_we) begin
            seen_cache_we   = 1'b1;
            obs_cache_addr  = cache_addr;
            obs_cache_wdata = cache_wdata;
        end
    endtask

    task automatic push_exp(input logic is_d, input int lat);
        exp_t e;
        e.is_d  = is_d;
        e.start = cyc;
        e.lat   = lat;
        e.rd    = model_rd;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic is_d, input logic we, input logic [23:0] addr,
                         input logic [31:0] wd, input logic found, input logic [31:0] crd,
                         input logic [31:0] rrd, input logic [31:0] exp_rd, input int lat,
                         input logic push);
        cache_found = found;
        cache_rdata = crd;
        ram_rdata   = rrd;
        seen_ram_cs = 1'b0; seen_ram_we = 1'b0; seen_cache_we = 1'b0; seen_both = 1'b0;
        obs_ram_addr = 24'd0; obs_cache_addr = 24'd0;
        obs_ram_wdata = 32'd0; obs_cache_wdata = 32'd0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        if (!(is_d && we)) model_rd = exp_rd;
        if (push) push_exp(is_d, lat);
    endtask

    task automatic wait_ack(input logic is_d);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            sample_bus();
            if ((is_d && d_ack) || (!is_d && f_ack)) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_arrived", {63'd0, got}, 64'd1);
        if (is_d) d_req = 1'b0;
        else f_req = 1'b0;
    endtask

    initial begin
        int fa, da;
        reset = 1'b1;
        f_req = 1'b0; f_addr = 24'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 24'd0; d_wdata = 32'd0;
        ram_rdata = 32'd0; cache_rdata = 32'd0; cache_found = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rdata", {32'd0, rdata}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_strobes", {59'd0, ram_cs, ram_we, ram_oe, cache_oe, cache_we}, 64'd0);
        check("reset_acks", {62'd0, f_ack, d_ack}, 64'd0);
        check("reset_addrs", {16'd0, ram_addr, cache_addr}, 64'd0);
        reset = 1'b0;

        // data write 0x11A <= 5
        issue(1'b1, 1'b1, 24'h11A, 32'h5, 1'b0, 32'h0, 32'h0, 32'h0, WR_LAT, 1'b1);
        wait_ack(1'b1);
        check("wr_ram_we", {63'd0, seen_ram_we}, 64'd1);
        check("wr_ram_addr", {40'd0, obs_ram_addr}, 64'h11A);
        check("wr_ram_wdata", {32'd0, obs_ram_wdata}, 64'h5);
`ifdef CACHE_MEM_CTRL_CACHE_EN
        check("wr_both_we", {63'd0, seen_both}, 64'd1);
        check("wr_cache_wdata", {32'd0, obs_cache_wdata}, 64'h5);
`else
        check("wr_no_cache_we", {63'd0, seen_cache_we}, 64'd0);
`endif
        @(negedge clk);

        // fetch 0x100 miss
        issue(1'b0, 1'b0, 24'h100, 32'h0, 1'b0, 32'hDEAD_0000, 32'h1000_011E, 32'h1000_011E, MISS_LAT, 1'b1);
        wait_ack(1'b0);
        check("fetch_ram_addr", {40'd0, obs_ram_addr}, 64'h100);
        check("fetch_no_write", {63'd0, seen_ram_we}, 64'd0);
`ifdef CACHE_MEM_CTRL_CACHE_EN
        check("fill_we", {63'd0, seen_cache_we}, 64'd1);
        check("fill_data", {32'd0, obs_cache_wdata}, 64'h1000_011E);
        check("fill_addr", {40'd0, obs_cache_addr}, 64'h100);
`endif
        @(negedge clk);

        // data read 0x11E, cache hit when enabled
        issue(1'b1, 1'b0, 24'h11E, 32'h0, 1'b1, 32'h7800_0000, 32'h2222_3333, T3_RD, HIT_LAT, 1'b1);
        wait_ack(1'b1);
`ifdef CACHE_MEM_CTRL_CACHE_EN
        check("hit_no_ram_cs", {63'd0, seen_ram_cs}, 64'd0);
`else
        check("rd_ram_addr", {40'd0, obs_ram_addr}, 64'h11E);
`endif
        @(negedge clk);

        // write must leave rdata untouched
        issue(1'b1, 1'b1, 24'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'h0, WR_LAT, 1'b1);
        wait_ack(1'b1);
        @(negedge clk);

        // read 0x120
        issue(1'b1, 1'b0, 24'h120, 32'h0, 1'b1, 32'h5A5A_5A5A, 32'h7800_0001, T5_RD, HIT_LAT, 1'b1);
        wait_ack(1'b1);
`ifndef CACHE_MEM_CTRL_CACHE_EN
        check("nocache_no_cwe", {63'd0, seen_cache_we}, 64'd0);
`endif
        @(negedge clk);

        // full-width address miss
        issue(1'b0, 1'b0, 24'hFF_FFFF, 32'h0, 1'b0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, MISS_LAT, 1'b1);
        wait_ack(1'b0);
        check("full_ram_addr", {40'd0, obs_ram_addr}, 64'hFF_FFFF);
`ifdef CACHE_MEM_CTRL_CACHE_EN
        check("full_cache_addr", {40'd0, obs_cache_addr}, 64'hFF_FFFF);
`endif
        @(negedge clk);

        // round robin from reset: fetch, data, fetch, data
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rd = 32'h1357_9BDF;
        cache_found = 1'b1; cache_rdata = 32'h1357_9BDF; ram_rdata = 32'h1357_9BDF;
        f_req = 1'b1; f_addr = 24'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 24'h300; d_wdata = 32'hABCD;
        begin
            exp_t e;
            e.rd = 32'h1357_9BDF;
            e.is_d = 1'b0; e.start = cyc;      e.lat = 3;      exp_q.push_back(e);
            e.is_d = 1'b1; e.start = cyc + 4;  e.lat = WR_LAT; exp_q.push_back(e);
            e.is_d = 1'b0; e.start = cyc + 7;  e.lat = 3;      exp_q.push_back(e);
            e.is_d = 1'b1; e.start = cyc + 11; e.lat = WR_LAT; exp_q.push_back(e);
        end
        fa = 0; da = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (f_ack) begin
                fa++;
                if (fa == 2) f_req = 1'b0;
            end
            if (d_ack) begin
                da++;
                if (da == 2) d_req = 1'b0;
            end
            if (fa == 2 && da == 2) break;
        end
        check("rr_fetch_acks", 64'(fa), 64'd2);
        check("rr_data_acks", 64'(da), 64'd2);
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // reset while in RAM_RD aborts; held request is served again
        issue(1'b1, 1'b0, 24'h400, 32'h0, 1'b0, 32'h0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, MISS_LAT, 1'b0);
        repeat (RD_CYC) @(negedge clk);
        check("abort_in_ram_rd", {62'd0, ram_cs, ram_oe}, 64'd3);
        reset = 1'b1;
        @(negedge clk);
        check("abort_quiet", {55'd0, f_ack, d_ack, busy, ram_cs, ram_we, ram_oe, cache_oe, cache_we, 1'b0}, 64'd0);
        check("abort_rdata", {32'd0, rdata}, 64'd0);
        reset = 1'b0;
        ram_rdata = 32'h600D_D00D;
        model_rd = 32'h600D_D00D;
        push_exp(1'b1, MISS_LAT);
        wait_ack(1'b1);
        @(negedge clk);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("bus_rules", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
